// File: rtl/vector_lane.sv
// One lane of the vector accelerator: walks elements my_id_i, my_id_i+lanes_p, ...
// Optional build macro VECTOR_LANE_SATURATE_EN clamps ALU add/sub instead of wrapping.
module vector_lane #(
    parameter int els_p      = 32,
    parameter int vlen_p     = 8,
    parameter int vdw_p      = 8,
    parameter int lanes_p    = 2,
    parameter int op_width_p = 4,
    localparam int id_w_lp   = (lanes_p > 1) ? $clog2(lanes_p) : 1,
    localparam int addr_w_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [id_w_lp-1:0]    my_id_i,
    input  logic [op_width_p-1:0] op_i,
    input  logic                  start_i,
    input  logic [vdw_p-1:0]      scalar_i,
    input  logic [vdw_p-1:0]      w_data_i,
    output logic [vdw_p-1:0]      r_data_o,
    output logic                  v_o,
    output logic                  done_o,
    output logic [addr_w_lp-1:0]  r_addr_o,
    input  logic [vdw_p-1:0]      r0_data_i,
    input  logic [vdw_p-1:0]      r1_data_i,
    output logic [addr_w_lp-1:0]  w_addr_o,
    output logic [vdw_p-1:0]      w_data_o,
    output logic                  w_en_o
);

    localparam int n_lp   = vlen_p / lanes_p;
    localparam int k_w_lp = (n_lp > 1) ? $clog2(n_lp) : 1;

    // Elaboration-time sanity checks on the configuration.
    if ((vlen_p % lanes_p) != 0 || els_p < 1 || op_width_p < 4) begin : g_bad_cfg
        $error("vector_lane: invalid parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [k_w_lp-1:0]       k_q;
    logic [op_width_p-1:0]   op_q;
    logic [vdw_p-1:0]        scalar_q;

    logic [addr_w_lp-1:0]    elem_addr;
    logic [vdw_p-1:0]        opnd_a, opnd_b, alu_res;
    logic                    is_alu, is_read, is_write;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            op_q     <= '0;
            scalar_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                op_q     <= op_i;
                scalar_q <= scalar_i;
                k_q      <= '0;
            end else if (state_q == BUSY) begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i) state_d = BUSY;
            BUSY: if (k_q == k_w_lp'(n_lp - 1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign is_alu   = ~op_q[3];
    assign is_read  = (op_q == op_width_p'(4'b1000));
    assign is_write = (op_q == op_width_p'(4'b1001));

    assign elem_addr = addr_w_lp'(my_id_i) + addr_w_lp'(k_q * lanes_p);

    assign opnd_a = r0_data_i;
    assign opnd_b = op_q[2] ? scalar_q : r1_data_i;

`ifdef VECTOR_LANE_SATURATE_EN
    logic [vdw_p:0] sum_ext;
    assign sum_ext = {1'b0, opnd_a} + {1'b0, opnd_b};
`endif

    always_comb begin
        alu_res = '0;
        unique case (op_q[1:0])
`ifdef VECTOR_LANE_SATURATE_EN
            2'b00: alu_res = sum_ext[vdw_p] ? '1 : sum_ext[vdw_p-1:0];
            2'b01: alu_res = (opnd_a < opnd_b) ? '0 : opnd_a - opnd_b;
`else
            2'b00: alu_res = opnd_a + opnd_b;
            2'b01: alu_res = opnd_a - opnd_b;
`endif
            2'b10: alu_res = opnd_a * opnd_b;
            2'b11: alu_res = opnd_a;
            default: alu_res = '0;
        endcase
    end

    // Outputs decode directly from the registered state so reset clears them next cycle.
    always_comb begin
        r_addr_o = '0;
        w_addr_o = '0;
        w_en_o   = 1'b0;
        w_data_o = '0;
        v_o      = 1'b0;
        r_data_o = '0;
        done_o   = 1'b0;
        if (state_q == BUSY) begin
            r_addr_o = elem_addr;
            w_addr_o = elem_addr;
            if (is_alu) begin
                w_en_o   = 1'b1;
                w_data_o = alu_res;
            end else if (is_write) begin
                w_en_o   = 1'b1;
                w_data_o = w_data_i;
            end else if (is_read) begin
                v_o      = 1'b1;
                r_data_o = r0_data_i;
            end
        end else if (state_q == DONE) begin
            done_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_vector_lane.sv
// Directed self-checking bench for vector_lane (default lanes_p=2, vlen_p=8, vdw_p=8).
module tb_vector_lane;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [0:0] my_id_i;
    logic [3:0] op_i;
    logic       start_i;
    logic [7:0] scalar_i, w_data_i;
    logic [7:0] r_data_o;
    logic       v_o, done_o;
    logic [2:0] r_addr_o, w_addr_o;
    logic [7:0] r0_data_i, r1_data_i;
    logic [7:0] w_data_o;
    logic       w_en_o;

    int total = 0;
    int bad   = 0;

    vector_lane #(.els_p(32), .vlen_p(8), .vdw_p(8), .lanes_p(2), .op_width_p(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .my_id_i(my_id_i), .op_i(op_i),
        .start_i(start_i), .scalar_i(scalar_i), .w_data_i(w_data_i),
        .r_data_o(r_data_o), .v_o(v_o), .done_o(done_o), .r_addr_o(r_addr_o),
        .r0_data_i(r0_data_i), .r1_data_i(r1_data_i), .w_addr_o(w_addr_o),
        .w_data_o(w_data_o), .w_en_o(w_en_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " done"},   32'(done_o),   0);
        check({tag, " v"},      32'(v_o),      0);
        check({tag, " wen"},    32'(w_en_o),   0);
        check({tag, " rdata"},  32'(r_data_o), 0);
        check({tag, " wdata"},  32'(w_data_o), 0);
        check({tag, " raddr"},  32'(r_addr_o), 0);
        check({tag, " waddr"},  32'(w_addr_o), 0);
    endtask

    // One full walk; inputs change at negedge, outputs sampled 1 time unit later.
    task automatic walk(input string name, input logic [3:0] op, input logic [7:0] scal,
                        input logic id, input logic [7:0] r0, input logic [7:0] r1,
                        input logic exp_wen, input logic exp_v, input logic [7:0] exp_d,
                        input logic inc, input logic poke);
        logic [7:0] d;
        logic [2:0] a;
        @(negedge clk_i);
        my_id_i = id; op_i = op; scalar_i = scal; r0_data_i = r0; r1_data_i = r1;
        start_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            start_i  = (poke && k == 1);
            op_i     = 4'b1111;
            scalar_i = 8'h00;
            d        = inc ? exp_d + 8'(k) : exp_d;
            w_data_i = inc ? d : 8'hA5;
            a        = 3'(id) + 3'(2 * k);
            #1;
            check($sformatf("%s raddr k%0d", name, k), 32'(r_addr_o), 32'(a));
            check($sformatf("%s waddr k%0d", name, k), 32'(w_addr_o), 32'(a));
            check($sformatf("%s wen k%0d", name, k),   32'(w_en_o),   32'(exp_wen));
            check($sformatf("%s wdata k%0d", name, k), 32'(w_data_o), exp_wen ? 32'(d) : 0);
            check($sformatf("%s v k%0d", name, k),     32'(v_o),      32'(exp_v));
            check($sformatf("%s rdata k%0d", name, k), 32'(r_data_o), exp_v ? 32'(d) : 0);
            check($sformatf("%s done k%0d", name, k),  32'(done_o),   0);
        end
        @(negedge clk_i);
        start_i = poke;
        #1;
        check({name, " done pulse"}, 32'(done_o), 1);
        check({name, " done wen"},   32'(w_en_o), 0);
        check({name, " done v"},     32'(v_o),    0);
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        check_quiet({name, " idle1"});
        @(negedge clk_i);
        #1;
        check_quiet({name, " idle2"});
    endtask

    initial begin
        reset_i = 1'b1; my_id_i = 1'b0; op_i = '0; start_i = 1'b0;
        scalar_i = '0; w_data_i = '0; r0_data_i = '0; r1_data_i = '0;
        repeat (3) @(negedge clk_i);
        #1;
        check_quiet("reset");
        reset_i = 1'b0;
        @(negedge clk_i);
        #1;
        check_quiet("post reset");

        walk("read0",  4'b1000, 8'h00, 1'b0, 8'h10, 8'h77, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        walk("write",  4'b1001, 8'h00, 1'b0, 8'h33, 8'h44, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0);
        walk("add",    4'b0000, 8'h99, 1'b0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h46, 1'b0, 1'b0);
        walk("subsc",  4'b0101, 8'h10, 1'b0, 8'h30, 8'h77, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
        walk("mul",    4'b0010, 8'h55, 1'b0, 8'h0A, 8'h03, 1'b1, 1'b0, 8'h1E, 1'b0, 1'b0);
        walk("mulsc",  4'b0110, 8'h11, 1'b1, 8'h13, 8'h02, 1'b1, 1'b0, 8'h43, 1'b0, 1'b0);
        walk("pass",   4'b0011, 8'h00, 1'b0, 8'h5C, 8'h01, 1'b1, 1'b0, 8'h5C, 1'b0, 1'b0);
`ifdef VECTOR_LANE_SATURATE_EN
        walk("addwrap", 4'b0000, 8'h00, 1'b0, 8'hF0, 8'h20, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        walk("subwrap", 4'b0001, 8'h00, 1'b0, 8'h05, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
`else
        walk("addwrap", 4'b0000, 8'h00, 1'b0, 8'hF0, 8'h20, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        walk("subwrap", 4'b0001, 8'h00, 1'b0, 8'h05, 8'h10, 1'b1, 1'b0, 8'hF5, 1'b0, 1'b0);
`endif
        walk("noop",   4'b1010, 8'h00, 1'b0, 8'h22, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        walk("read1",  4'b1000, 8'h00, 1'b1, 8'hC3, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1);

        // Reset on the second BUSY cycle abandons the walk without done_o.
        @(negedge clk_i);
        my_id_i = 1'b0; op_i = 4'b1000; r0_data_i = 8'h10; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        check("rst busy0 v", 32'(v_o), 1);
        @(negedge clk_i);
        #1;
        check("rst busy1 raddr", 32'(r_addr_o), 2);
        reset_i = 1'b1;
        @(negedge clk_i);
        #1;
        check_quiet("rst applied");
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #1;
            check($sformatf("rst no done %0d", i), 32'(done_o), 0);
            check($sformatf("rst no v %0d", i),    32'(v_o),    0);
        end
        walk("after rst", 4'b1000, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
